// File: rtl/top_pkg.sv
// Shared definitions for the burst word-store block: sizes, FSM states and memory reset pattern.
package top_pkg;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    localparam logic [DATA_W-1:0] MEM_RST_BASE = 32'hA000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Reset contents of word idx: base pattern tagged with its own address.
    function automatic logic [DATA_W-1:0] mem_rst_val(input logic [ADDR_W-1:0] idx);
        return MEM_RST_BASE + {{(DATA_W-ADDR_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/top_mem.sv
// 16 x 32-bit word store: one synchronous write port, one registered read port.
module top_mem
    import top_pkg::*;
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Every word is reloaded on reset, so an aborted burst leaves no trace.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_rst_val(ADDR_W'(i));
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/top.sv
// Burst read/write controller: command accept, pointer/beat counter FSM around top_mem.
module top
    import top_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_top_wr,
    input  logic              io_top_rd,
    input  logic [ADDR_W-1:0] io_top_address,
    input  logic [LEN_W-1:0]  io_top_length,
    input  logic [DATA_W-1:0] io_top_wdata,
    input  logic              io_top_ready,
    input  logic              io_top_rddatavalid,
    output logic [DATA_W-1:0] io_top_rdata
);

    // Assert asynchronously, release on a clock edge so no register sees a runt release.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [LEN_W-1:0]  cnt, cnt_d;
    logic              mem_we, mem_re;
    logic [LEN_W-1:0]  len_beats;

    // A zero length still moves one word.
    assign len_beats = (io_top_length == '0) ? LEN_W'(1) : io_top_length;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        unique case (state)
            IDLE: begin
                // Write wins when both requests arrive together.
                if ((io_top_rd || io_top_wr) && io_top_ready) begin
                    ptr_d   = io_top_address;
                    cnt_d   = len_beats;
                    state_d = io_top_wr ? WRITE : READ;
                end
            end
            READ: begin
                if (io_top_rddatavalid) begin
                    mem_re = 1'b1;
                    ptr_d  = ptr + ADDR_W'(1);
                    cnt_d  = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (io_top_ready) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr + ADDR_W'(1);
                    cnt_d  = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    top_mem u_mem (
        .clock (clock),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (ptr),
        .wdata (io_top_wdata),
        .re    (mem_re),
        .raddr (ptr),
        .rdata (io_top_rdata)
    );

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed burst scenarios plus randomized traffic against a memory model.
module tb_top;

    logic        clock;
    logic        reset;
    logic        io_top_wr;
    logic        io_top_rd;
    logic [3:0]  io_top_address;
    logic [3:0]  io_top_length;
    logic [31:0] io_top_wdata;
    logic        io_top_ready;
    logic        io_top_rddatavalid;
    logic [31:0] io_top_rdata;

    top dut (
        .clock              (clock),
        .reset              (reset),
        .io_top_wr          (io_top_wr),
        .io_top_rd          (io_top_rd),
        .io_top_address     (io_top_address),
        .io_top_length      (io_top_length),
        .io_top_wdata       (io_top_wdata),
        .io_top_ready       (io_top_ready),
        .io_top_rddatavalid (io_top_rddatavalid),
        .io_top_rdata       (io_top_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: word array plus the last value the read port should be showing.
    logic [31:0] mem_m [16];
    logic [31:0] exp_rdata;
    int          n_tests;
    int          n_fail;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_rdata(input string name);
        n_tests++;
        if (io_top_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s: rdata=%h expected=%h at %0t", name, io_top_rdata, exp_rdata, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = 32'hA000_0000 + 32'(i);
        exp_rdata = 32'h0;
    endtask

    task automatic drive_idle();
        io_top_wr          = 1'b0;
        io_top_rd          = 1'b0;
        io_top_address     = 4'd0;
        io_top_length      = 4'd0;
        io_top_wdata       = 32'd0;
        io_top_ready       = 1'b0;
        io_top_rddatavalid = 1'b0;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        repeat (3) tick();
    endtask

    // A read strobe with no command pending must not move the read port.
    task automatic idle_strobe_check(input string name);
        io_top_rddatavalid = 1'b1;
        io_top_ready       = 1'b1;
        tick();
        io_top_rddatavalid = 1'b0;
        io_top_ready       = 1'b0;
        check_rdata(name);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int pre_wait,
                           input int first_stall, input bit rnd_stall, input int stop_after);
        int          n;
        logic [3:0]  p;
        io_top_rd      = 1'b1;
        io_top_address = a;
        io_top_length  = l;
        io_top_ready   = 1'b0;
        repeat (pre_wait) begin
            io_top_rddatavalid = 1'($urandom % 2);
            tick();
            check_rdata("rd_wait_no_accept");
        end
        io_top_ready       = 1'b1;
        io_top_rddatavalid = 1'($urandom % 2);
        tick();
        check_rdata("rd_accept_no_beat");
        io_top_rd      = 1'b0;
        io_top_address = 4'($urandom);
        io_top_length  = 4'($urandom);
        n = (l == 4'd0) ? 1 : int'(l);
        p = a;
        for (int k = 0; k < n && k < stop_after; k++) begin
            int stalls;
            stalls = (k == 0) ? first_stall : 0;
            if (rnd_stall) stalls = stalls + int'($urandom_range(0, 2));
            repeat (stalls) begin
                io_top_rddatavalid = 1'b0;
                io_top_ready       = 1'($urandom % 2);
                tick();
                check_rdata("rd_stall_hold");
            end
            io_top_rddatavalid = 1'b1;
            io_top_ready       = 1'($urandom % 2);
            tick();
            exp_rdata = mem_m[p];
            p = p + 4'd1;
            check_rdata("rd_beat");
        end
        io_top_rddatavalid = 1'b0;
        io_top_ready       = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] l, input bit both,
                            input bit fixed, input bit rnd_stall);
        int          n;
        logic [3:0]  p;
        logic [31:0] v;
        io_top_wr          = 1'b1;
        io_top_rd          = both;
        io_top_address     = a;
        io_top_length      = l;
        io_top_ready       = 1'b1;
        io_top_rddatavalid = 1'($urandom % 2);
        tick();
        check_rdata("wr_accept_hold");
        io_top_wr      = 1'b0;
        io_top_rd      = 1'b0;
        io_top_address = 4'($urandom);
        io_top_length  = 4'($urandom);
        n = (l == 4'd0) ? 1 : int'(l);
        p = a;
        for (int k = 0; k < n; k++) begin
            if (rnd_stall) begin
                repeat ($urandom_range(0, 2)) begin
                    io_top_ready       = 1'b0;
                    io_top_wdata       = $urandom;
                    io_top_rddatavalid = 1'($urandom % 2);
                    tick();
                    check_rdata("wr_stall_hold");
                end
            end
            v = fixed ? 32'(11 * (k + 1)) : $urandom;
            io_top_ready       = 1'b1;
            io_top_wdata       = v;
            io_top_rddatavalid = 1'($urandom % 2);
            tick();
            mem_m[p] = v;
            p = p + 4'd1;
            check_rdata("wr_beat_hold");
        end
        io_top_ready       = 1'b0;
        io_top_rddatavalid = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        model_reset();
        repeat (2) tick();
        check_rdata("reset_rdata");
        release_reset();
        check_rdata("post_reset_rdata");
    endtask

    task automatic test_single_read();
        do_read(4'd4, 4'd1, 2, 0, 1'b0, 16);
        idle_strobe_check("single_read_back_idle");
    endtask

    task automatic test_stalled_read();
        do_read(4'd5, 4'd3, 0, 1, 1'b0, 16);
        idle_strobe_check("stalled_read_back_idle");
    endtask

    task automatic test_write_wrap();
        do_write(4'd14, 4'd3, 1'b0, 1'b1, 1'b0);
        do_read(4'd14, 4'd3, 0, 0, 1'b0, 16);
    endtask

    task automatic test_rd_wr_both();
        logic [3:0] a;
        a = 4'($urandom);
        do_write(a, 4'd1, 1'b1, 1'b0, 1'b0);
        do_read(a, 4'd1, 0, 0, 1'b0, 16);
    endtask

    task automatic test_len_zero();
        do_read(4'd9, 4'd0, 0, 0, 1'b0, 16);
        idle_strobe_check("len0_one_beat");
    endtask

    task automatic test_reset_mid_burst();
        do_read(4'd0, 4'd4, 0, 0, 1'b0, 2);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_rdata("midburst_reset_rdata");
        drive_idle();
        repeat (2) tick();
        release_reset();
        idle_strobe_check("midburst_aborted_idle");
        do_read(4'd0, 4'd15, 0, 0, 1'b0, 16);
        do_read(4'd15, 4'd1, 0, 0, 1'b0, 16);
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 30; i++) begin
            logic [3:0] a;
            logic [3:0] l;
            a = 4'($urandom);
            l = 4'($urandom);
            if ($urandom % 2) do_write(a, l, 1'($urandom % 2), 1'b0, 1'b1);
            else              do_read(a, l, int'($urandom_range(0, 2)), 0, 1'b1, 16);
        end
        do_read(4'd0, 4'd15, 0, 0, 1'b1, 16);
        do_read(4'd15, 4'd1, 0, 0, 1'b0, 16);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single_read();
        test_stalled_read();
        test_write_wrap();
        test_rd_wr_both();
        test_len_zero();
        test_reset_mid_burst();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
